// File: rtl/ext_accel_pwr_ctrl.sv
// ext_accel_pwr_ctrl
// Per-channel power sequencer for external accelerators: power switch,
// isolation, reset release and clock enable, plus per-channel interrupt
// pending bits mapped onto an MCU interrupt vector.
// Optional feature: define EXT_ACCEL_ACK_TIMEOUT_EN to build a switch-ack
// timeout that parks a channel in ERR when the acknowledge never arrives.
module ext_accel_pwr_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int NEXT_INT    = 64,
  parameter int INT_BASE    = 0,
  parameter int ISO_DELAY   = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_CH-1:0]   pwr_on_req_i,
  input  logic [NUM_CH-1:0]   pwr_off_req_i,
  input  logic [NUM_CH-1:0]   powergate_switch_ack_i,
  input  logic [NUM_CH-1:0]   accel_int_i,
  input  logic [NUM_CH-1:0]   int_clr_i,
  input  logic [NUM_CH-1:0]   int_mask_i,
  output logic [NUM_CH-1:0]   powergate_switch_o,
  output logic [NUM_CH-1:0]   powergate_iso_o,
  output logic [NUM_CH-1:0]   subsystem_rst_no,
  output logic [NUM_CH-1:0]   clk_en_o,
  output logic [NUM_CH-1:0]   ch_on_o,
  output logic [NUM_CH-1:0]   ch_err_o,
  output logic [NEXT_INT-1:0] intr_vector_o
);

  typedef enum logic [2:0] {
    S_OFF,
    S_PWR_UP,
    S_ISO_WAIT,
    S_RST_REL,
    S_ON,
    S_PWR_DN,
    S_ERR
  } state_t;

`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
  // Counter only needs to reach ACK_TIMEOUT-1 before the state is abandoned.
  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
`endif

  // Parameter sanity checks, evaluated at elaboration.
  if (INT_BASE + NUM_CH > NEXT_INT) begin : g_bad_int_map
    $error("ext_accel_pwr_ctrl: INT_BASE+NUM_CH exceeds NEXT_INT");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("ext_accel_pwr_ctrl: NUM_CH must be 1..8");
  end
  if (ISO_DELAY < 1 || ISO_DELAY > 255) begin : g_bad_iso_delay
    $error("ext_accel_pwr_ctrl: ISO_DELAY must be 1..255");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
    $error("ext_accel_pwr_ctrl: ACK_TIMEOUT must be at least 1");
  end

  logic [NUM_CH-1:0] ack_meta_q;
  logic [NUM_CH-1:0] ack_sync_q;
  logic [NUM_CH-1:0] pending_q;

  // Two-flop synchroniser for the asynchronous power-switch acknowledges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_meta_q <= '0;
      ack_sync_q <= '0;
    end else begin
      ack_meta_q <= powergate_switch_ack_i;
      ack_sync_q <= ack_meta_q;
    end
  end

  // Interrupt pending bits: set only while running, set beats clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= (accel_int_i & ch_on_o) | (pending_q & ~int_clr_i);
    end
  end

  for (genvar b = 0; b < NEXT_INT; b++) begin : g_intr
    if (b >= INT_BASE && b < INT_BASE + NUM_CH) begin : g_map
      assign intr_vector_o[b] = pending_q[b-INT_BASE] & int_mask_i[b-INT_BASE];
    end else begin : g_zero
      assign intr_vector_o[b] = 1'b0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t     state_q, state_d;
    logic [7:0] iso_cnt_q, iso_cnt_d;
    logic       on_req, off_req, ack;
    logic       sw, iso, rst_n, clk_en, on;
`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_expired;
`endif

    assign on_req  = pwr_on_req_i[c];
    assign off_req = pwr_off_req_i[c];
    assign ack     = ack_sync_q[c];

`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
    assign to_expired = (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));
`endif

    // State and dwell counters.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q   <= S_OFF;
        iso_cnt_q <= '0;
`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
        to_cnt_q  <= '0;
`endif
      end else begin
        state_q   <= state_d;
        iso_cnt_q <= iso_cnt_d;
`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
        to_cnt_q  <= to_cnt_d;
`endif
      end
    end

    // Next-state and Moore output decode; off always beats on.
    always_comb begin
      state_d = state_q;
      sw      = 1'b0;
      iso     = 1'b1;
      rst_n   = 1'b0;
      clk_en  = 1'b0;
      on      = 1'b0;
      case (state_q)
        S_OFF: begin
          if (on_req && !off_req) state_d = S_PWR_UP;
        end
        S_PWR_UP: begin
          sw = 1'b1;
          if (off_req) state_d = S_PWR_DN;
          else if (ack) state_d = S_ISO_WAIT;
`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
          else if (to_expired) state_d = S_ERR;
`endif
        end
        S_ISO_WAIT: begin
          sw = 1'b1;
          if (off_req) state_d = S_PWR_DN;
          else if (iso_cnt_q == 8'(ISO_DELAY - 1)) state_d = S_RST_REL;
        end
        S_RST_REL: begin
          sw      = 1'b1;
          iso     = 1'b0;
          clk_en  = 1'b1;
          state_d = off_req ? S_PWR_DN : S_ON;
        end
        S_ON: begin
          sw     = 1'b1;
          iso    = 1'b0;
          clk_en = 1'b1;
          rst_n  = 1'b1;
          on     = 1'b1;
          if (off_req) state_d = S_PWR_DN;
        end
        S_PWR_DN: begin
          if (!ack) state_d = S_OFF;
`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
          else if (to_expired) state_d = S_ERR;
`endif
        end
        S_ERR: begin
          if (off_req) state_d = S_OFF;
        end
        default: state_d = S_OFF;
      endcase

      // Counters restart on every state entry; each only runs in the
      // states that consume it.
      iso_cnt_d = (state_q == S_ISO_WAIT) ? iso_cnt_q + 8'd1 : '0;
`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
      if (state_d != state_q || !(state_q == S_PWR_UP || state_q == S_PWR_DN))
        to_cnt_d = '0;
      else
        to_cnt_d = to_cnt_q + TO_W'(1);
`endif
    end

    assign powergate_switch_o[c] = sw;
    assign powergate_iso_o[c]    = iso;
    assign subsystem_rst_no[c]   = rst_n;
    assign clk_en_o[c]           = clk_en;
    assign ch_on_o[c]            = on;
`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
    assign ch_err_o[c]           = (state_q == S_ERR);
`else
    assign ch_err_o[c]           = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ext_accel_pwr_ctrl.sv
// Testbench for ext_accel_pwr_ctrl: directed sequences plus randomized
// traffic checked against a timestamp-based reference model.
module tb_ext_accel_pwr_ctrl;
  localparam int NUM_CH      = 4;
  localparam int NEXT_INT    = 16;
  localparam int INT_BASE    = 8;
  localparam int ISO_DELAY   = 4;
  localparam int ACK_TIMEOUT = 16;
`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int P_OFF = 0, P_UP = 1, P_ISO = 2, P_RREL = 3, P_ON = 4, P_DN = 5, P_ERR = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH-1:0] on_req, off_req, ack, accel_int, int_clr, int_mask;
  logic [NUM_CH-1:0] sw, iso, rst_n, clk_en, ch_on, ch_err;
  logic [NEXT_INT-1:0] intr;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase per channel, edge number of phase entry,
  // acknowledge as seen two edges late, pending bits.
  int     m_ph    [NUM_CH];
  longint m_entry [NUM_CH];
  bit     m_s1    [NUM_CH];
  bit     m_s2    [NUM_CH];
  bit     m_pend  [NUM_CH];
  longint edge_no = 0;

  ext_accel_pwr_ctrl #(
    .NUM_CH     (NUM_CH),
    .NEXT_INT   (NEXT_INT),
    .INT_BASE   (INT_BASE),
    .ISO_DELAY  (ISO_DELAY),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .pwr_on_req_i          (on_req),
    .pwr_off_req_i         (off_req),
    .powergate_switch_ack_i(ack),
    .accel_int_i           (accel_int),
    .int_clr_i             (int_clr),
    .int_mask_i            (int_mask),
    .powergate_switch_o    (sw),
    .powergate_iso_o       (iso),
    .subsystem_rst_no      (rst_n),
    .clk_en_o              (clk_en),
    .ch_on_o               (ch_on),
    .ch_err_o              (ch_err),
    .intr_vector_o         (intr)
  );

  always #5 clk = ~clk;

  // Advance the model with the inputs the DUT will sample at this edge.
  task automatic model_edge();
    int     nxt;
    longint age;
    bit     sa, on, off;
    edge_no++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        m_ph[c] = P_OFF; m_entry[c] = edge_no;
        m_s1[c] = 0; m_s2[c] = 0; m_pend[c] = 0;
      end else begin
        sa  = m_s2[c];
        on  = on_req[c];
        off = off_req[c];
        age = edge_no - m_entry[c];
        nxt = m_ph[c];
        m_pend[c] = (accel_int[c] && m_ph[c] == P_ON) || (m_pend[c] && !int_clr[c]);
        case (m_ph[c])
          P_OFF:  if (on && !off) nxt = P_UP;
          P_UP:   if (off) nxt = P_DN; else if (sa) nxt = P_ISO;
                  else if (TO_EN && age == ACK_TIMEOUT) nxt = P_ERR;
          P_ISO:  if (off) nxt = P_DN; else if (age == ISO_DELAY) nxt = P_RREL;
          P_RREL: nxt = off ? P_DN : P_ON;
          P_ON:   if (off) nxt = P_DN;
          P_DN:   if (!sa) nxt = P_OFF;
                  else if (TO_EN && age == ACK_TIMEOUT) nxt = P_ERR;
          P_ERR:  if (off) nxt = P_OFF;
          default: nxt = P_OFF;
        endcase
        if (nxt != m_ph[c]) begin
          m_ph[c]    = nxt;
          m_entry[c] = edge_no;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = ack[c];
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    on_req = '1;
    tick();
    on_req = '0;
    tick(); tick();
    n_vec++; if (sw !== '0)     begin n_err++; $display("FAIL reset_switch: got %b expected 0000", sw); end
    n_vec++; if (iso !== '1)    begin n_err++; $display("FAIL reset_iso: got %b expected 1111", iso); end
    n_vec++; if (rst_n !== '0)  begin n_err++; $display("FAIL reset_rst_n: got %b expected 0000", rst_n); end
    n_vec++; if (clk_en !== '0) begin n_err++; $display("FAIL reset_clk_en: got %b expected 0000", clk_en); end
    n_vec++; if (ch_on !== '0)  begin n_err++; $display("FAIL reset_ch_on: got %b expected 0000", ch_on); end
    n_vec++; if (ch_err !== '0) begin n_err++; $display("FAIL reset_ch_err: got %b expected 0000", ch_err); end
    n_vec++; if (intr !== '0)   begin n_err++; $display("FAIL reset_intr: got %h expected 0", intr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_power_up();
    on_req[0] = 1'b1; tick(); on_req[0] = 1'b0;
    n_vec++; if (sw[0] !== 1'b1) begin n_err++; $display("FAIL pu_switch_next: got %b expected 1", sw[0]); end
    tick(); tick();
    n_vec++; if (iso[0] !== 1'b1 || ch_on[0] !== 1'b0)
      begin n_err++; $display("FAIL pu_waiting: got iso=%b on=%b expected iso=1 on=0", iso[0], ch_on[0]); end
    ack[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_vec++; if (iso[0] !== (k < 7))
        begin n_err++; $display("FAIL pu_iso_edge%0d: got %b expected %b", k, iso[0], (k < 7)); end
      n_vec++; if (clk_en[0] !== (k >= 7))
        begin n_err++; $display("FAIL pu_clk_en_edge%0d: got %b expected %b", k, clk_en[0], (k >= 7)); end
      n_vec++; if (ch_on[0] !== (k >= 8))
        begin n_err++; $display("FAIL pu_ch_on_edge%0d: got %b expected %b", k, ch_on[0], (k >= 8)); end
      n_vec++; if (rst_n[0] !== (k >= 8))
        begin n_err++; $display("FAIL pu_rst_n_edge%0d: got %b expected %b", k, rst_n[0], (k >= 8)); end
    end
  endtask

  task automatic test_power_down();
    on_req[1] = 1'b1; tick(); on_req[1] = 1'b0;
    ack[1] = 1'b1;
    repeat (10) tick();
    n_vec++; if (ch_on[1] !== 1'b1) begin n_err++; $display("FAIL pd_on_first: got %b expected 1", ch_on[1]); end
    off_req[1] = 1'b1; tick(); off_req[1] = 1'b0;
    n_vec++; if ({sw[1], iso[1], clk_en[1], rst_n[1], ch_on[1]} !== 5'b01000)
      begin n_err++; $display("FAIL pd_outputs: got %b expected 01000",
                              {sw[1], iso[1], clk_en[1], rst_n[1], ch_on[1]}); end
    tick();
    ack[1] = 1'b0;
    tick(); tick();
    on_req[1] = 1'b1; tick(); on_req[1] = 1'b0;
    n_vec++; if (sw[1] !== 1'b0) begin n_err++; $display("FAIL pd_on_ignored_edge3: got %b expected 0", sw[1]); end
    on_req[1] = 1'b1; tick(); on_req[1] = 1'b0;
    n_vec++; if (sw[1] !== 1'b1) begin n_err++; $display("FAIL pd_off_reached: got %b expected 1", sw[1]); end
    off_req[1] = 1'b1; tick(); off_req[1] = 1'b0;
    n_vec++; if (sw[1] !== 1'b0) begin n_err++; $display("FAIL pd_abort_pwr_up: got %b expected 0", sw[1]); end
    tick(); tick();
  endtask

  task automatic test_abort();
    on_req[3] = 1'b1; off_req[3] = 1'b1; tick(); on_req[3] = 1'b0; off_req[3] = 1'b0;
    n_vec++; if (sw[3] !== 1'b0) begin n_err++; $display("FAIL ab_on_off_same: got %b expected 0", sw[3]); end
    tick();
    n_vec++; if (sw[3] !== 1'b0) begin n_err++; $display("FAIL ab_no_queue: got %b expected 0", sw[3]); end
    on_req[3] = 1'b1; tick(); on_req[3] = 1'b0;
    ack[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) off_req[3] = 1'b1;
      tick();
      off_req[3] = 1'b0;
      n_vec++; if (clk_en[3] !== 1'b0) begin n_err++; $display("FAIL ab_no_rst_rel_%0d: got %b expected 0", k, clk_en[3]); end
    end
    n_vec++; if ({sw[3], iso[3]} !== 2'b01)
      begin n_err++; $display("FAIL ab_iso_wait_off: got %b expected 01", {sw[3], iso[3]}); end
    ack[3] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_interrupts();
    logic [NEXT_INT-1:0] exp_v;
    exp_v = '0;
    exp_v[INT_BASE+2] = 1'b1;
    int_mask = '1;
    accel_int[3] = 1'b1; tick(); accel_int[3] = 1'b0;
    n_vec++; if (intr !== '0) begin n_err++; $display("FAIL int_off_ignored: got %h expected 0", intr); end
    on_req[2] = 1'b1; tick(); on_req[2] = 1'b0;
    ack[2] = 1'b1;
    repeat (10) tick();
    n_vec++; if (ch_on[2] !== 1'b1) begin n_err++; $display("FAIL int_ch2_on: got %b expected 1", ch_on[2]); end
    accel_int[2] = 1'b1; tick(); accel_int[2] = 1'b0;
    n_vec++; if (intr !== exp_v) begin n_err++; $display("FAIL int_set: got %h expected %h", intr, exp_v); end
    repeat (3) tick();
    n_vec++; if (intr !== exp_v) begin n_err++; $display("FAIL int_held: got %h expected %h", intr, exp_v); end
    int_mask[2] = 1'b0; #1;
    n_vec++; if (intr !== '0) begin n_err++; $display("FAIL int_masked: got %h expected 0", intr); end
    int_mask[2] = 1'b1; #1;
    int_clr[2] = 1'b1; tick(); int_clr[2] = 1'b0;
    n_vec++; if (intr !== '0) begin n_err++; $display("FAIL int_cleared: got %h expected 0", intr); end
    accel_int[2] = 1'b1; int_clr[2] = 1'b1; tick(); accel_int[2] = 1'b0; int_clr[2] = 1'b0;
    n_vec++; if (intr !== exp_v) begin n_err++; $display("FAIL int_set_wins: got %h expected %h", intr, exp_v); end
    int_clr[2] = 1'b1; tick(); int_clr[2] = 1'b0;
  endtask

  task automatic test_reset_mid();
    accel_int[0] = 1'b1; tick(); accel_int[0] = 1'b0;
    n_vec++; if (intr[INT_BASE] !== 1'b1) begin n_err++; $display("FAIL rm_pending: got %b expected 1", intr[INT_BASE]); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_vec++; if ({sw, iso, rst_n, clk_en, ch_on, ch_err} !== {4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0})
      begin n_err++; $display("FAIL rm_outputs: got %h expected 0f0000", {sw, iso, rst_n, clk_en, ch_on, ch_err}); end
    n_vec++; if (intr !== '0) begin n_err++; $display("FAIL rm_intr: got %h expected 0", intr); end
    ack = '0;
    repeat (3) tick();
  endtask

`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
  task automatic test_timeout();
    on_req[0] = 1'b1; tick(); on_req[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_vec++; if (ch_err[0] !== (k >= 16))
        begin n_err++; $display("FAIL to_err_edge%0d: got %b expected %b", k, ch_err[0], (k >= 16)); end
      n_vec++; if (sw[0] !== (k < 16))
        begin n_err++; $display("FAIL to_switch_edge%0d: got %b expected %b", k, sw[0], (k < 16)); end
    end
    on_req[0] = 1'b1; tick(); on_req[0] = 1'b0;
    n_vec++; if ({ch_err[0], sw[0]} !== 2'b10)
      begin n_err++; $display("FAIL to_on_ignored: got %b expected 10", {ch_err[0], sw[0]}); end
    off_req[0] = 1'b1; tick(); off_req[0] = 1'b0;
    n_vec++; if ({ch_err[0], sw[0], iso[0]} !== 3'b001)
      begin n_err++; $display("FAIL to_err_cleared: got %b expected 001", {ch_err[0], sw[0], iso[0]}); end
  endtask
`endif

  task automatic test_random();
    logic [NUM_CH-1:0]   e_sw, e_iso, e_rstn, e_clken, e_on, e_err;
    logic [NEXT_INT-1:0] e_intr;
    int ph;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(399) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        ph = m_ph[c];
        if ($urandom_range(2) == 0) ack[c] = (ph == P_UP || ph == P_ISO || ph == P_RREL || ph == P_ON);
        if ($urandom_range(59) == 0) ack[c] = ~ack[c];
        on_req[c]    = ($urandom_range(7) == 0);
        off_req[c]   = ($urandom_range(23) == 0);
        accel_int[c] = ($urandom_range(3) == 0);
        int_clr[c]   = ($urandom_range(5) == 0);
        if ($urandom_range(19) == 0) int_mask[c] = ~int_mask[c];
      end
      tick();
      e_intr = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ph = m_ph[c];
        e_sw[c]    = (ph == P_UP || ph == P_ISO || ph == P_RREL || ph == P_ON);
        e_iso[c]   = !(ph == P_RREL || ph == P_ON);
        e_clken[c] = (ph == P_RREL || ph == P_ON);
        e_rstn[c]  = (ph == P_ON);
        e_on[c]    = (ph == P_ON);
        e_err[c]   = (ph == P_ERR);
        e_intr[INT_BASE+c] = m_pend[c] & int_mask[c];
      end
      n_vec++; if (sw !== e_sw)        begin n_err++; $display("FAIL rnd_switch@%0d: got %b expected %b", n, sw, e_sw); end
      n_vec++; if (iso !== e_iso)      begin n_err++; $display("FAIL rnd_iso@%0d: got %b expected %b", n, iso, e_iso); end
      n_vec++; if (rst_n !== e_rstn)   begin n_err++; $display("FAIL rnd_rst_n@%0d: got %b expected %b", n, rst_n, e_rstn); end
      n_vec++; if (clk_en !== e_clken) begin n_err++; $display("FAIL rnd_clk_en@%0d: got %b expected %b", n, clk_en, e_clken); end
      n_vec++; if (ch_on !== e_on)     begin n_err++; $display("FAIL rnd_ch_on@%0d: got %b expected %b", n, ch_on, e_on); end
      n_vec++; if (ch_err !== e_err)   begin n_err++; $display("FAIL rnd_ch_err@%0d: got %b expected %b", n, ch_err, e_err); end
      n_vec++; if (intr !== e_intr)    begin n_err++; $display("FAIL rnd_intr@%0d: got %h expected %h", n, intr, e_intr); end
    end
    rst = 1'b0;
  endtask

  initial begin
    on_req = '0; off_req = '0; ack = '0;
    accel_int = '0; int_clr = '0; int_mask = '0;
    test_reset();
    test_power_up();
    test_power_down();
    test_abort();
    test_interrupts();
    test_reset_mid();
`ifdef EXT_ACCEL_ACK_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ext_accel_pwr_ctrl.md
EXT_ACCEL_PWR_CTRL -- requirements
Module: ext_accel_pwr_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of external accelerator channels (1..8).
REQ-002 SHALL have parameter NEXT_INT, default 64, meaning width of the external interrupt vector.
REQ-003 SHALL have parameter INT_BASE, default 0, meaning interrupt line assigned to channel 0; channel c uses INT_BASE+c.
REQ-004 SHALL have parameter ISO_DELAY, default 4, meaning cycles between switch-ack and isolation release (1..255).
REQ-005 SHALL have parameter ACK_TIMEOUT, default 1024, meaning maximum cycles waiting for a switch acknowledge.
REQ-006 SHALL have ports:
  clk_i  in  1  clock; one clock domain.
  rst_i  in  1  reset, synchronous, active-high.
  pwr_on_req_i  in  NUM_CH  one-cycle request to power a channel on.
  pwr_off_req_i  in  NUM_CH  one-cycle request to power a channel off.
  powergate_switch_ack_i  in  NUM_CH  asynchronous power-switch acknowledge.
  accel_int_i  in  NUM_CH  level interrupt from each accelerator.
  int_clr_i  in  NUM_CH  one-cycle clear of a pending interrupt.
  int_mask_i  in  NUM_CH  1 = interrupt enabled.
  powergate_switch_o  out  NUM_CH  power-switch enable.
  powergate_iso_o  out  NUM_CH  isolation enable, 1 = isolated.
  subsystem_rst_no  out  NUM_CH  accelerator logic reset, active-low.
  clk_en_o  out  NUM_CH  accelerator clock-gate enable.
  ch_on_o  out  NUM_CH  channel fully powered and running.
  ch_err_o  out  NUM_CH  channel acknowledge timeout.
  intr_vector_o  out  NEXT_INT  interrupt lines to the MCU.

Function
REQ-007 SHALL run one independent FSM per channel: OFF, PWR_UP, ISO_WAIT, RST_REL, ON, PWR_DN, ERR.
REQ-008 SHALL synchronise powergate_switch_ack_i through a 2-flop synchroniser; the FSM acts only on the synchronised ack.
REQ-009 OFF: switch=0, iso=1, rst_no=0, clk_en=0; pwr_on_req_i moves the FSM to PWR_UP, and switch_o is 1 on the next cycle.
REQ-010 PWR_UP: switch=1; synchronised ack=1 moves the FSM to ISO_WAIT.
REQ-011 ISO_WAIT: switch=1, iso=1; the FSM stays exactly ISO_DELAY cycles, then moves to RST_REL.
REQ-012 RST_REL: iso=0, clk_en=1, rst_no=0 for exactly 1 cycle, then ON.
REQ-013 ON: iso=0, clk_en=1, rst_no=1, ch_on_o=1; pwr_off_req_i moves the FSM to PWR_DN.
REQ-014 PWR_DN: iso=1, clk_en=0, rst_no=0, switch=0 all from the first PWR_DN cycle; synchronised ack=0 moves the FSM to OFF.
REQ-015 pwr_off_req_i in PWR_UP, ISO_WAIT or RST_REL SHALL abort to PWR_DN.
REQ-016 pwr_on_req_i in any state other than OFF SHALL be ignored; requests are never queued.
REQ-017 Simultaneous on and off requests for one channel SHALL resolve as off.
REQ-018 ERR: switch=0, iso=1, rst_no=0, clk_en=0, ch_err_o=1; only pwr_off_req_i leaves ERR, going to OFF and clearing ch_err_o; pwr_on_req_i in ERR is ignored.
REQ-019 A per-channel pending bit SHALL be set when accel_int_i=1 in state ON; accel_int_i SHALL be ignored in all other states.
REQ-020 A pending bit SHALL be cleared by int_clr_i; if set and clear occur in the same cycle, set wins.
REQ-021 intr_vector_o[INT_BASE+c] SHALL equal pending[c] & int_mask_i[c]; all other bits SHALL be 0.
REQ-022 Elaboration SHALL fail if INT_BASE+NUM_CH > NEXT_INT.
REQ-023 Channels SHALL never interact; events on different channels in the same cycle are processed independently.

Reset
REQ-024 While rst_i=1, every FSM SHALL be in OFF and the synchronisers, pending bits and counters SHALL be 0.
REQ-025 Reset output values: switch=0, iso=1, rst_no=0, clk_en=0, ch_on=0, ch_err=0, intr_vector=0.
REQ-026 Reset asserted mid-sequence SHALL force OFF immediately without the PWR_DN handshake.

Configuration
REQ-027 With macro EXT_ACCEL_ACK_TIMEOUT_EN defined: a per-channel counter, started on entry to PWR_UP or PWR_DN, moves the FSM to ERR when the state has been occupied for ACK_TIMEOUT cycles without the required ack.
REQ-028 Without EXT_ACCEL_ACK_TIMEOUT_EN: PWR_UP and PWR_DN wait indefinitely, ERR is unreachable, ch_err_o is tied to 0 and no counter is built.

Verification
REQ-029 ISO_DELAY=4: pwr_on_req ch0, ack_i raised 3 cycles later -> ch_on_o[0] rises on the 8th edge counting the first edge that samples ack=1; iso falls 1 cycle earlier.
REQ-030 ch1 ON, pwr_off_req -> iso=1, clk_en=0, rst_no=0, switch=0 next cycle; drop ack -> OFF 3 cycles later.
REQ-031 Timeout enabled, ACK_TIMEOUT=16, ack never given -> ch_err_o=1 and switch_o=0 after 16 PWR_UP cycles; pwr_off_req -> OFF, ch_err_o=0.
REQ-032 INT_BASE=8, ch2 ON, accel_int pulse, mask=1 -> intr_vector_o[10]=1 until int_clr; int_clr coinciding with accel_int -> bit stays 1.
REQ-033 Simultaneous on+off in OFF -> no change; off during ISO_WAIT -> PWR_DN with no RST_REL.
REQ-034 rst_i asserted in ON -> all outputs at reset values the next cycle, intr_vector_o=0.
